key_select_encoder: RTL and testbench

// - Upstream stage of decoder2_4: turns four raw active-low push-buttons (board KEY[3:0]) into a registered 2-bit code.
// - The 2-bit code is the index of the most recently pressed key.
// - sel drives decoder2_4.in directly. The decoder's one-hot out then lights the LED matching the last key pressed.
// - Per-key logic: 2-flop synchronizer, then debouncer, then press-edge detector. A single-winner encoder follows, with a hold register.

---
 rtl/key_select_encoder.sv | 129 ++++++++++++
 tb/tb_key_select_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_select_encoder.sv
// key_select_encoder: four active-low push-buttons -> registered 2-bit index
// of the most recently pressed key, feeding decoder2_4.in.
// Per key: 2-flop synchronizer, debouncer, press-edge detector; then a
// single-winner encoder with a hold register.
// Optional build macro SEL_ROUND_ROBIN_EN: round-robin winner selection among
// simultaneous presses instead of fixed highest-index priority.
module key_select_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       clear,
  output logic [3:0] key_state,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       press_pulse
);

  // Counter value on which the next increment would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       act_p1;
  logic [CNT_W-1:0] cnt_p1 [4];
  logic [3:0]       key_state_d_p2;
  logic [3:0]       press_p2;
  logic             any_press_p2;
  logic [1:0]       win_p2;

  // Stage 0/1: two-flop synchronizer; flops idle at 1 (button released).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 4'hF;
      sync_p1 <= 4'hF;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  assign act_p1 = ~sync_p1;

  // Stage 1 -> key_state: per-key debounce; level flips only after a full run of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_state <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (act_p1[i] == key_state[i]) begin
          cnt_p1[i] <= '0;
        end else if (cnt_p1[i] == CNT_LAST) begin
          key_state[i] <= ~key_state[i];
          cnt_p1[i]    <= '0;
        end else begin
          cnt_p1[i] <= cnt_p1[i] + 1'b1;
        end
      end
    end
  end

  // Stage 2: delayed debounced level for rising-edge (press) detection.
  always_ff @(posedge clk) begin
    if (reset) key_state_d_p2 <= 4'b0000;
    else       key_state_d_p2 <= key_state;
  end

  // Release edges are deliberately ignored; only new presses compete.
  assign press_p2     = key_state & ~key_state_d_p2;
  assign any_press_p2 = |press_p2;

`ifdef SEL_ROUND_ROBIN_EN
  logic [1:0] ptr;
  logic [1:0] cand_p2;
  logic       found_p2;

  // Round-robin pick: search starts just after the last winner and wraps to it.
  always_comb begin
    win_p2   = ptr;
    cand_p2  = ptr;
    found_p2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand_p2 = ptr + 2'(k);
      if (!found_p2 && press_p2[cand_p2]) begin
        win_p2   = cand_p2;
        found_p2 = 1'b1;
      end
    end
  end

  // Pointer remembers the last winner; clear leaves it alone.
  always_ff @(posedge clk) begin
    if (reset)             ptr <= 2'd3;
    else if (any_press_p2) ptr <= win_p2;
  end
`else
  // Fixed priority pick: the highest pressed index wins.
  always_comb begin
    win_p2 = 2'd0;
    if (press_p2[3])      win_p2 = 2'd3;
    else if (press_p2[2]) win_p2 = 2'd2;
    else if (press_p2[1]) win_p2 = 2'd1;
    else                  win_p2 = 2'd0;
  end
`endif

  // Stage 3: hold register; a press beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel         <= 2'b00;
      sel_valid   <= 1'b0;
      press_pulse <= 1'b0;
    end else if (any_press_p2) begin
      sel         <= win_p2;
      sel_valid   <= 1'b1;
      press_pulse <= 1'b1;
    end else begin
      press_pulse <= 1'b0;
      if (clear) begin
        sel       <= 2'b00;
        sel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_select_encoder.sv
// Testbench for key_select_encoder with DEBOUNCE_CYCLES = 4.
// Expected accepted presses (sel value and the cycle its pulse is due) are
// queued when keys are driven and matched against press_pulse by a monitor.
module tb_key_select_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       clear;
  logic [3:0] key_state;
  logic [1:0] sel;
  logic       sel_valid;
  logic       press_pulse;

  typedef struct {
    logic [1:0] sel;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  key_select_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .clear      (clear),
    .key_state  (key_state),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the oldest expected press.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      total++; bad++;
      $display("FAIL pulse_missing cyc=%0d got=none want_sel=%0d due=%0d", cyc, exp_q[0].sel, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (press_pulse === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected cyc=%0d got_sel=%0d want=no pulse", cyc, sel);
      end else begin
        e = exp_q.pop_front();
        if (sel !== e.sel || cyc != e.due) begin
          bad++;
          $display("FAIL pulse_match got sel=%0d cyc=%0d want sel=%0d cyc=%0d", sel, cyc, e.sel, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; key_n = 4'hF; clear = 1'b0;
    step(3);
    total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL rst_key_state got=%b want=0000", key_state); end
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL rst_sel got=%b want=00", sel); end
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL rst_sel_valid got=%b want=0", sel_valid); end
    total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got=%b want=0", press_pulse); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_press_key2;
    int k;
    k = cyc;
    key_n = 4'b1011;
    exp_q.push_back('{2'd2, k + 3 + D});
    step(D + 1);
    total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL k2_early got=%b want=0000", key_state); end
    step(1);
    total++; if (key_state !== 4'b0100) begin bad++; $display("FAIL k2_state got=%b want=0100", key_state); end
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL k2_valid_early got=%b want=0", sel_valid); end
    step(1);
    total++; if (sel !== 2'b10) begin bad++; $display("FAIL k2_sel got=%b want=10", sel); end
    total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL k2_valid got=%b want=1", sel_valid); end
    total++; if (press_pulse !== 1'b1) begin bad++; $display("FAIL k2_pulse got=%b want=1", press_pulse); end
    total++; if ((4'b0001 << sel) !== 4'b0100) begin bad++; $display("FAIL k2_decoder got=%b want=0100", 4'b0001 << sel); end
    step(1);
    total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL k2_pulse_width got=%b want=0", press_pulse); end
  endtask

  task automatic test_glitch;
    key_n = 4'b1001;
    for (int i = 0; i < 3; i++) step(1);
    key_n = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      step(1);
      total++; if (key_state !== 4'b0100 || sel !== 2'b10) begin bad++; $display("FAIL glitch got state=%b sel=%b want state=0100 sel=10", key_state, sel); end
    end
  endtask

  task automatic test_release;
    key_n = 4'hF;
    step(D + 4);
    total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL rel_state got=%b want=0000", key_state); end
    total++; if (sel !== 2'b10 || sel_valid !== 1'b1) begin bad++; $display("FAIL rel_sel got sel=%b v=%b want sel=10 v=1", sel, sel_valid); end
  endtask

  task automatic test_simultaneous;
    int k;
    logic [1:0] want2;
`ifdef SEL_ROUND_ROBIN_EN
    want2 = 2'd0;
`else
    want2 = 2'd3;
`endif
    k = cyc;
    key_n = 4'b0110;
    exp_q.push_back('{2'd3, k + 3 + D});
    step(D + 3);
    total++; if (sel !== 2'd3) begin bad++; $display("FAIL sim1_sel got=%0d want=3", sel); end
    key_n = 4'hF;
    step(D + 4);
    k = cyc;
    key_n = 4'b0110;
    exp_q.push_back('{want2, k + 3 + D});
    step(D + 3);
    total++; if (sel !== want2) begin bad++; $display("FAIL sim2_sel got=%0d want=%0d", sel, want2); end
    key_n = 4'hF;
    step(D + 4);
  endtask

  task automatic test_clear;
    int k;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    total++; if (sel !== 2'd0 || sel_valid !== 1'b0) begin bad++; $display("FAIL clr_idle got sel=%0d v=%b want sel=0 v=0", sel, sel_valid); end
    k = cyc;
    key_n = 4'b1101;
    exp_q.push_back('{2'd1, k + 3 + D});
    step(D + 2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    total++; if (sel !== 2'd1 || sel_valid !== 1'b1 || press_pulse !== 1'b1) begin
      bad++; $display("FAIL clr_press got sel=%0d v=%b p=%b want sel=1 v=1 p=1", sel, sel_valid, press_pulse);
    end
    key_n = 4'hF;
    step(D + 4);
  endtask

  task automatic test_reset_mid;
    int r;
    key_n = 4'b1011;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    r = cyc;
    total++; if (key_state !== 4'b0000 || sel !== 2'd0 || sel_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst got state=%b sel=%0d v=%b want 0000 0 0", key_state, sel, sel_valid);
    end
    exp_q.push_back('{2'd2, r + 3 + D});
    step(D + 1);
    total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL mid_early got=%b want=0000", key_state); end
    step(1);
    total++; if (key_state !== 4'b0100) begin bad++; $display("FAIL mid_state got=%b want=0100", key_state); end
    step(2);
    total++; if (sel !== 2'd2 || sel_valid !== 1'b1) begin bad++; $display("FAIL mid_sel got sel=%0d v=%b want sel=2 v=1", sel, sel_valid); end
    key_n = 4'hF;
    step(D + 4);
  endtask

  initial begin
    reset = 1'b1; key_n = 4'hF; clear = 1'b0;
    test_reset();
    test_press_key2();
    test_glitch();
    test_release();
    test_simultaneous();
    test_clear();
    test_reset_mid();
    step(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
